divider_scratch_mem_ctrl: RTL and testbench

Memory-side sequencer for the histogram-equalization divider stage. On a start pulse it walks every CDF entry in scratch memory. For each entry it reads the entry and the divisor, waits for the divider to finish, and writes the quotient back to a result region. It sits between the scratch-memory port and the divider datapath, issuing addresses and enables only; data paths are external.

---
 rtl/divider_scratch_mem_ctrl_pkg.sv | 28 ++
 rtl/divider_scratch_mem_ctrl.sv | 99 +++++++++
 tb/tb_divider_scratch_mem_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/divider_scratch_mem_ctrl_pkg.sv
// Shared definitions for the histogram-equalization divider stage: address width,
// scratch-memory map defaults and the memory-side sequencer state encoding.
package divider_scratch_mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned IDX_W  = 9;

    // Default scratch-memory map, also used by the divider datapath.
    localparam logic [ADDR_W-1:0] DEF_CDF_BASE     = 16'h0000;
    localparam logic [ADDR_W-1:0] DEF_DIVISOR_ADDR = 16'h0100;
    localparam logic [ADDR_W-1:0] DEF_RESULT_BASE  = 16'h0200;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdAck,
        StWaitDiv,
        StWr,
        StWrAck
    } state_e;

    // Base plus entry index, truncated to the address width.
    function automatic logic [ADDR_W-1:0] idx_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
        return base + {{(ADDR_W - IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/divider_scratch_mem_ctrl.sv
// Memory-side sequencer for the divider stage. On a start request it walks every CDF
// entry: read entry and divisor, wait for the divider, write the quotient back.
// Only addresses and strobes are produced; all data paths are external.
module divider_scratch_mem_ctrl
    import divider_scratch_mem_ctrl_pkg::*;
#(
    parameter int unsigned       N_ENTRIES    = 256,
    parameter logic [ADDR_W-1:0] CDF_BASE     = DEF_CDF_BASE,
    parameter logic [ADDR_W-1:0] DIVISOR_ADDR = DEF_DIVISOR_ADDR,
    parameter logic [ADDR_W-1:0] RESULT_BASE  = DEF_RESULT_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              div_done,
    output logic [ADDR_W-1:0] sc_mem_rd_addr1,
    output logic [ADDR_W-1:0] sc_mem_rd_addr2,
    output logic [ADDR_W-1:0] sc_mem_wt_addr,
    output logic              sc_mem_rd_en,
    output logic              sc_mem_wt_en,
    output logic              sc_mem_rd_done,
    output logic              sc_mem_wt_done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_ENTRIES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] rd_addr1_q, wt_addr_q;
    logic              rd_en_q, wt_en_q, rd_done_q, wt_done_q;

    // Next state and next index; enable and div_done only matter in their own states.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (enable) begin
                    state_d = StRd;
                end
            end
            StRd:    state_d = StRdAck;
            StRdAck: state_d = StWaitDiv;
            StWaitDiv: begin
                if (div_done) begin
                    state_d = StWr;
                end
            end
            StWr:    state_d = StWrAck;
            StWrAck: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    state_d = StRd;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // State, index and outputs all registered; strobes decode the state being entered
    // so each one is high exactly while the FSM sits in its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_done_q  <= 1'b0;
            wt_en_q    <= 1'b0;
            wt_done_q  <= 1'b0;
            rd_addr1_q <= CDF_BASE;
            wt_addr_q  <= RESULT_BASE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_en_q    <= (state_d == StRd);
            rd_done_q  <= (state_d == StRdAck);
            wt_en_q    <= (state_d == StWr);
            wt_done_q  <= (state_d == StWrAck);
            rd_addr1_q <= idx_addr(CDF_BASE, idx_d);
            wt_addr_q  <= idx_addr(RESULT_BASE, idx_d);
        end
    end

    assign sc_mem_rd_addr1 = rd_addr1_q;
    assign sc_mem_rd_addr2 = DIVISOR_ADDR;
    assign sc_mem_wt_addr  = wt_addr_q;
    assign sc_mem_rd_en    = rd_en_q;
    assign sc_mem_wt_en    = wt_en_q;
    assign sc_mem_rd_done  = rd_done_q;
    assign sc_mem_wt_done  = wt_done_q;

endmodule

// File: tb/tb_divider_scratch_mem_ctrl.sv
// Scoreboard bench for divider_scratch_mem_ctrl: expected read/write addresses are
// queued when a run is launched and popped by a monitor on every strobe.
module tb_divider_scratch_mem_ctrl;

    localparam int NUM = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        div_done;
    logic [15:0] rd_addr1, rd_addr2, wt_addr;
    logic        rd_en, wt_en, rd_done, wt_done;

    divider_scratch_mem_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .div_done        (div_done),
        .sc_mem_rd_addr1 (rd_addr1),
        .sc_mem_rd_addr2 (rd_addr2),
        .sc_mem_wt_addr  (wt_addr),
        .sc_mem_rd_en    (rd_en),
        .sc_mem_wt_en    (wt_en),
        .sc_mem_rd_done  (rd_done),
        .sc_mem_wt_done  (wt_done)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          wr_cnt = 0;
    int          last_wtdone_cyc = 0;
    int          dd_mode = 0;  // 0: tied 1, 1: toggle, 2: random, 3: manual
    logic [15:0] exp_rd_q[$];
    logic [15:0] exp_wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // div_done pattern generator
    always @(posedge clk) begin
        #1;
        case (dd_mode)
            0: div_done = 1'b1;
            1: div_done = ~div_done;
            2: div_done = ($urandom_range(0, 3) == 0);
            default: ;
        endcase
    end

    // Monitor: pop expected addresses whenever a strobe appears
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if ((rd_en + wt_en + rd_done + wt_done) > 1)
                check("strobe_onehot", {28'd0, rd_en, rd_done, wt_en, wt_done}, 32'd0);
            if (rd_en) begin
                check("rd_addr2", rd_addr2, 16'h0100);
                check("rd_expected", exp_rd_q.size() != 0, 1);
                if (exp_rd_q.size() != 0) check("rd_addr1", rd_addr1, exp_rd_q.pop_front());
            end
            if (wt_en) begin
                wr_cnt++;
                check("wr_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) check("wt_addr", wt_addr, exp_wr_q.pop_front());
                check("addr_pair", wt_addr - 16'h0200, rd_addr1 - 16'h0000);
            end
            if (wt_done) last_wtdone_cyc = cyc;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_done"}, rd_done, 0);
        check({tag, "_wt_en"}, wt_en, 0);
        check({tag, "_wt_done"}, wt_done, 0);
        check({tag, "_rd_addr1"}, rd_addr1, 16'h0000);
        check({tag, "_rd_addr2"}, rd_addr2, 16'h0100);
        check({tag, "_wt_addr"}, wt_addr, 16'h0200);
    endtask

    // Queue the whole run's expected addresses, then pulse enable for one sampled edge.
    task automatic launch_run();
        wr_cnt = 0;
        for (int i = 0; i < NUM; i++) begin
            exp_rd_q.push_back(16'(i));
            exp_wr_q.push_back(16'h0200 + 16'(i));
        end
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int bound);
        for (int i = 0; i < bound && wr_cnt < NUM; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_writes"}, wr_cnt, NUM);
        check({tag, "_rdq_left"}, exp_rd_q.size(), 0);
        check({tag, "_wrq_left"}, exp_wr_q.size(), 0);
        repeat (8) @(negedge clk);
        check({tag, "_idle_rd_en"}, rd_en, 0);
        check({tag, "_idle_rd_addr1"}, rd_addr1, 16'h0000);
    endtask

    task automatic wait_rd_done_entry(input logic [15:0] addr, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rd_done && rd_addr1 == addr) break;
        end
        check("entry_reached", i < bound, 1);
    endtask

    initial begin
        int start_cyc;
        int w0;
        reset    = 1'b0;
        enable   = 1'b0;
        div_done = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Idle after reset
        repeat (6) @(negedge clk);
        check_reset_vals("idle");

        // Exact latency with div_done tied high
        dd_mode = 0;
        launch_run();
        @(negedge clk); start_cyc = cyc;
        check("lat_c1_rd_en", rd_en, 1);
        @(negedge clk); check("lat_c2_rd_done", rd_done, 1);
        @(negedge clk); check("lat_c3_quiet", {rd_en, rd_done, wt_en, wt_done}, 4'b0000);
        @(negedge clk); check("lat_c4_wt_en", wt_en, 1);
        @(negedge clk); check("lat_c5_wt_done", wt_done, 1);
        @(negedge clk); check("lat_c6_rd_addr1", rd_addr1, 16'h0001);
        repeat (3) @(negedge clk); check("lat_c9_wt_addr", wt_addr, 16'h0201);
        finish_run("tied", 5000);
        check("tied_run_cycles", last_wtdone_cyc - start_cyc + 1, 5 * NUM);

        // div_done toggling, plus a second enable pulse mid-run that must be ignored
        dd_mode = 1;
        launch_run();
        repeat (300) @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        finish_run("toggle", 8000);

        // Random div_done
        dd_mode = 2;
        launch_run();
        finish_run("random", 20000);

        // Stall entry 3 for 20 cycles
        dd_mode  = 3;
        div_done = 1'b1;
        launch_run();
        wait_rd_done_entry(16'h0003, 100);
        @(posedge clk); #1 div_done = 1'b0;
        w0 = wr_cnt;
        repeat (20) @(posedge clk);
        check("stall_no_wr", wr_cnt, w0);
        #1 div_done = 1'b1;
        @(negedge clk); check("stall_still_wait", wt_en, 0);
        @(negedge clk);
        check("stall_wt_en", wt_en, 1);
        check("stall_wt_addr", wt_addr, 16'h0203);
        finish_run("stall", 5000);

        // Reset during WAIT_DIV of entry 10
        dd_mode  = 3;
        div_done = 1'b1;
        launch_run();
        wait_rd_done_entry(16'h000a, 200);
        @(posedge clk); #1 div_done = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals("midrst");
        check("midrst_writes", wr_cnt, 10);
        exp_rd_q.delete();
        exp_wr_q.delete();
        repeat (3) @(posedge clk);
        #1 check("midrst_hold_wt_en", wt_en, 0);
        #1 reset = 1'b1;
        dd_mode = 0;
        launch_run();
        @(negedge clk);
        check("restart_rd_en", rd_en, 1);
        check("restart_rd_addr1", rd_addr1, 16'h0000);
        finish_run("restart", 5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
